// File: rtl/trap_pkg.sv
// Shared encodings for the machine-mode trap sequencer: FSM states,
// interrupt cause codes and the vectored-mode stride.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        TAKE  = 3'd2,
        DRAIN = 3'd3,
        WFI   = 3'd4
    } trap_state_t;

    typedef struct packed {
        logic me;
        logic ms;
        logic mt;
    } cause_t;

    localparam logic [4:0]  CAUSE_MEI  = 5'd11;
    localparam logic [4:0]  CAUSE_MSI  = 5'd3;
    localparam logic [4:0]  CAUSE_MTI  = 5'd7;
    localparam logic [31:0] VEC_STRIDE = 32'd4;

    // Byte offset into the vector table for a latched one-hot cause.
    function automatic logic [31:0] vec_offset(input cause_t c);
        logic [4:0] code;
        code = CAUSE_MTI;
        if (c.ms) code = CAUSE_MSI;
        if (c.me) code = CAUSE_MEI;
        return VEC_STRIDE * {27'd0, code};
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-stage flip-flop synchroniser bank for the asynchronous
// platform interrupt levels.
module irq_sync #(
    parameter int STAGES = 2,
    parameter int W      = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: interrupt arbitration, CSR trap strobes,
// pipeline flush and fetch redirect. Optional WFI support: TRAP_CTRL_WFI_EN.
//
// state | meaning
// IDLE  | waiting for exception, mret or enabled interrupt
// ARM   | interrupt selected, fetch held, waiting for a valid EX/MEM boundary
// TAKE  | one-cycle int_take strobe to the CSR file
// DRAIN | flush asserted for FLUSH_CYC cycles after a redirect
// WFI   | sleeping until any enabled interrupt pends (optional)
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int FLUSH_CYC   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic        ext_irq,
    input  logic        tmr_irq,
    input  logic        sw_irq,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic        mie_msie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        wb_exp,
    input  logic        wb_mret,
    input  logic        ex2mem_valid,
`ifdef TRAP_CTRL_WFI_EN
    input  logic        wb_wfi,
    output logic        wfi_sleep,
`endif
    output logic        int_take,
    output logic        i_me,
    output logic        i_ms,
    output logic        i_mt,
    output logic [2:0]  mip_pend,
    output logic        flush,
    output logic        fetch_hold,
    output logic        redirect_vld,
    output logic [31:0] redirect_pc
);

    localparam logic [2:0] DRAIN_LOAD = 3'(FLUSH_CYC - 1);

    trap_state_t state_q, state_d;
    cause_t      cause_q, sel;
    logic [2:0]  drain_cnt_q;
    logic [2:0]  pend;
    logic        fire;
    logic        redir_go;
    logic        latch_cause;
    logic [31:0] redir_tgt;
    logic [31:0] vec_base;

    irq_sync #(
        .STAGES (SYNC_STAGES),
        .W      (3)
    ) u_irq_sync (
        .clk   (clk),
        .rst_n (cpurst_n),
        .din   ({sw_irq, tmr_irq, ext_irq}),
        .dout  (mip_pend)
    );

    assign pend     = mip_pend & {mie_msie, mie_mtie, mie_meie};
    assign fire     = mstatus_mie & (|pend);
    assign vec_base = mtvec & 32'hFFFF_FFFC;

    // Priority meip > msip > mtip.
    assign sel.me = pend[0];
    assign sel.ms = pend[2] & ~pend[0];
    assign sel.mt = pend[1] & ~pend[0] & ~pend[2];

    always_comb begin
        state_d     = state_q;
        redir_go    = 1'b0;
        redir_tgt   = vec_base;
        latch_cause = 1'b0;
        case (state_q)
            IDLE, ARM: begin
                if (wb_exp) begin
                    state_d  = DRAIN;
                    redir_go = 1'b1;
                end else if (wb_mret) begin
                    state_d   = DRAIN;
                    redir_go  = 1'b1;
                    redir_tgt = mepc;
                end else if (state_q == IDLE) begin
                    if (fire) begin
                        state_d     = ARM;
                        latch_cause = 1'b1;
                    end
`ifdef TRAP_CTRL_WFI_EN
                    else if (wb_wfi) begin
                        state_d = WFI;
                    end
`endif
                end else if (!fire) begin
                    state_d = IDLE;
                end else if (ex2mem_valid) begin
                    state_d = TAKE;
                end
            end
            TAKE: begin
                state_d   = DRAIN;
                redir_go  = 1'b1;
                redir_tgt = vec_base + vec_offset(cause_q);
            end
            DRAIN: begin
                if (drain_cnt_q == 3'd0) state_d = IDLE;
            end
`ifdef TRAP_CTRL_WFI_EN
            WFI: begin
                if (|pend) begin
                    if (mstatus_mie) begin
                        state_d     = ARM;
                        latch_cause = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q      <= IDLE;
            cause_q      <= '0;
            drain_cnt_q  <= '0;
            redirect_vld <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            state_q      <= state_d;
            redirect_vld <= redir_go;
            if (redir_go) redirect_pc <= redir_tgt;
            if (latch_cause) cause_q <= sel;
            // Every redirect enters DRAIN, so the load rides on redir_go.
            if (redir_go) begin
                drain_cnt_q <= DRAIN_LOAD;
            end else if (state_q == DRAIN && drain_cnt_q != 3'd0) begin
                drain_cnt_q <= drain_cnt_q - 3'd1;
            end
        end
    end

    assign int_take = (state_q == TAKE);
    assign i_me     = int_take & cause_q.me;
    assign i_ms     = int_take & cause_q.ms;
    assign i_mt     = int_take & cause_q.mt;
    assign flush    = (state_q == DRAIN);

`ifdef TRAP_CTRL_WFI_EN
    assign fetch_hold = (state_q == ARM) || (state_q == WFI);
    assign wfi_sleep  = (state_q == WFI);
`else
    assign fetch_hold = (state_q == ARM);
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl (default build, WFI disabled).
module tb_trap_ctrl;

    logic        clk;
    logic        cpurst_n;
    logic        ext_irq, tmr_irq, sw_irq;
    logic        mstatus_mie, mie_meie, mie_mtie, mie_msie;
    logic [31:0] mtvec, mepc;
    logic        wb_exp, wb_mret, ex2mem_valid;
    logic        int_take, i_me, i_ms, i_mt;
    logic [2:0]  mip_pend;
    logic        flush, fetch_hold, redirect_vld;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    trap_ctrl #(
        .FLUSH_CYC   (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .cpurst_n     (cpurst_n),
        .ext_irq      (ext_irq),
        .tmr_irq      (tmr_irq),
        .sw_irq       (sw_irq),
        .mstatus_mie  (mstatus_mie),
        .mie_meie     (mie_meie),
        .mie_mtie     (mie_mtie),
        .mie_msie     (mie_msie),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .wb_exp       (wb_exp),
        .wb_mret      (wb_mret),
        .ex2mem_valid (ex2mem_valid),
        .int_take     (int_take),
        .i_me         (i_me),
        .i_ms         (i_ms),
        .i_mt         (i_mt),
        .mip_pend     (mip_pend),
        .flush        (flush),
        .fetch_hold   (fetch_hold),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        cpurst_n     = 1'b0;
        ext_irq      = 1'b1;
        tmr_irq      = 1'b1;
        sw_irq       = 1'b0;
        mstatus_mie  = 1'b1;
        mie_meie     = 1'b1;
        mie_mtie     = 1'b1;
        mie_msie     = 1'b1;
        mtvec        = 32'h8000_0001;
        mepc         = 32'h0;
        wb_exp       = 1'b0;
        wb_mret      = 1'b0;
        ex2mem_valid = 1'b1;

        // Reset held with interrupts pending: everything quiet.
        repeat (3) tick();
        chk1("rst_int_take", int_take, 1'b0);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_fetch_hold", fetch_hold, 1'b0);
        chk1("rst_redirect_vld", redirect_vld, 1'b0);
        chk32("rst_redirect_pc", redirect_pc, 32'h0);
        chk32("rst_mip_pend", {29'd0, mip_pend}, 32'h0);

        // Release: two sync edges, one to arm, one to take.
        cpurst_n = 1'b1;
        tick();
        chk1("sync1_int_take", int_take, 1'b0);
        chk32("sync1_mip_pend", {29'd0, mip_pend}, 32'h0);
        tick();
        chk1("sync2_int_take", int_take, 1'b0);
        chk32("sync2_mip_pend", {29'd0, mip_pend}, 32'h3);
        tick();
        chk1("arm_int_take", int_take, 1'b0);
        chk1("arm_fetch_hold", fetch_hold, 1'b1);
        tick();
        chk1("take_int_take", int_take, 1'b1);
        chk1("take_i_me", i_me, 1'b1);
        chk1("take_i_mt", i_mt, 1'b0);
        chk1("take_i_ms", i_ms, 1'b0);
        mstatus_mie = 1'b0;
        tick();
        chk1("me_redirect_vld", redirect_vld, 1'b1);
        chk32("me_redirect_pc", redirect_pc, 32'h8000_002C);
        chk1("me_flush_c1", flush, 1'b1);
        chk1("me_no_int_take", int_take, 1'b0);
        tick();
        chk1("me_flush_c2", flush, 1'b1);
        chk1("me_redirect_vld_c2", redirect_vld, 1'b0);
        tick();
        chk1("me_flush_end", flush, 1'b0);
        chk1("me_idle_hold", fetch_hold, 1'b0);

        // Vector arithmetic wraps modulo 2^32.
        mtvec       = 32'hFFFF_FFF2;
        mstatus_mie = 1'b1;
        tick();
        chk1("wrap_arm", fetch_hold, 1'b1);
        tick();
        chk1("wrap_i_me", i_me, 1'b1);
        mstatus_mie = 1'b0;
        tick();
        chk32("wrap_redirect_pc", redirect_pc, 32'h0000_001C);
        tick();
        tick();
        chk1("wrap_flush_end", flush, 1'b0);
        mtvec = 32'h8000_0001;

        // Software beats timer; boundary withheld for 5 cycles.
        ext_irq      = 1'b0;
        sw_irq       = 1'b1;
        ex2mem_valid = 1'b0;
        repeat (3) tick();
        chk32("ms_mip_pend", {29'd0, mip_pend}, 32'h6);
        mstatus_mie = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("wait_fetch_hold", fetch_hold, 1'b1);
            chk1("wait_no_int_take", int_take, 1'b0);
        end
        ex2mem_valid = 1'b1;
        tick();
        chk1("ms_int_take", int_take, 1'b1);
        chk1("ms_i_ms", i_ms, 1'b1);
        chk1("ms_i_mt", i_mt, 1'b0);
        mstatus_mie  = 1'b0;
        ex2mem_valid = 1'b0;
        tick();
        chk1("ms_redirect_vld", redirect_vld, 1'b1);
        chk32("ms_redirect_pc", redirect_pc, 32'h8000_000C);
        tick();
        tick();
        chk1("ms_flush_end", flush, 1'b0);

        // Exception at the boundary pre-empts the armed interrupt.
        mstatus_mie = 1'b1;
        tick();
        chk1("exp_arm_hold", fetch_hold, 1'b1);
        wb_exp       = 1'b1;
        ex2mem_valid = 1'b1;
        tick();
        chk1("exp_no_int_take", int_take, 1'b0);
        chk1("exp_redirect_vld", redirect_vld, 1'b1);
        chk32("exp_redirect_pc", redirect_pc, 32'h8000_0000);
        chk1("exp_flush", flush, 1'b1);
        wb_exp       = 1'b0;
        ex2mem_valid = 1'b0;
        mstatus_mie  = 1'b0;
        tick();
        chk1("exp_drain_no_take", int_take, 1'b0);
        tick();
        chk1("exp_flush_end", flush, 1'b0);

        // mret redirects to mepc; exception wins over mret.
        sw_irq  = 1'b0;
        tmr_irq = 1'b0;
        repeat (3) tick();
        mepc    = 32'h0000_1234;
        wb_mret = 1'b1;
        tick();
        chk1("mret_redirect_vld", redirect_vld, 1'b1);
        chk32("mret_redirect_pc", redirect_pc, 32'h0000_1234);
        wb_mret = 1'b0;
        tick();
        chk1("mret_vld_pulse", redirect_vld, 1'b0);
        tick();
        chk1("mret_flush_end", flush, 1'b0);
        wb_mret = 1'b1;
        wb_exp  = 1'b1;
        tick();
        chk1("both_redirect_vld", redirect_vld, 1'b1);
        chk32("both_redirect_pc", redirect_pc, 32'h8000_0000);
        wb_mret = 1'b0;
        wb_exp  = 1'b0;
        tick();
        tick();
        chk1("both_flush_end", flush, 1'b0);

        // Reset during DRAIN cycle 1 aborts cleanly.
        wb_exp = 1'b1;
        tick();
        wb_exp = 1'b0;
        chk1("abort_flush_pre", flush, 1'b1);
        chk1("abort_vld_pre", redirect_vld, 1'b1);
        cpurst_n = 1'b0;
        #1;
        chk1("abort_flush", flush, 1'b0);
        chk1("abort_redirect_vld", redirect_vld, 1'b0);
        @(negedge clk);
        cpurst_n = 1'b1;
        tick();
        chk1("abort_idle_flush", flush, 1'b0);
        chk1("abort_idle_vld", redirect_vld, 1'b0);
        chk1("abort_idle_hold", fetch_hold, 1'b0);
        chk1("abort_idle_take", int_take, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
